// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer in front of the shared 4 KB data
// memory. Port m0 is the CPU data port, m1 the loader/debug port. Every
// granted access spends one BUSY cycle driving the memory, then returns a
// one-cycle ack with registered load data.
//
// Build option: define DM_ARB_ROUND_ROBIN_EN to break ties by granting the
// port that was not granted last. Left undefined, m0 wins every tie.
module dm_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [2:0]        m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic [2:0]        m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              dm_we,
  output logic              dm_sb,
  output logic              dm_lb,
  output logic              dm_lbu,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  input  logic [31:0]       dm_dout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [2:0] CMD_SW  = 3'b001;
  localparam logic [2:0] CMD_SB  = 3'b010;
  localparam logic [2:0] CMD_LB  = 3'b011;
  localparam logic [2:0] CMD_LBU = 3'b100;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;   // 0 = m0, 1 = m1
  logic        last_q, last_d;     // port of the most recent grant
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic              elig0, elig1, pick1;
  logic [2:0]        own_cmd;
  logic [ADDR_W-1:0] own_addr;
  logic [31:0]       own_wdata;
  logic              busy, own_store, own_load;

  // Eligibility and tie-break: a port in its ack cycle cannot be re-granted.
  always_comb begin
    elig0 = m0_req & ~m0_ack_q;
    elig1 = m1_req & ~m1_ack_q;
`ifdef DM_ARB_ROUND_ROBIN_EN
    // On a tie, m1 goes only if m0 was granted last.
    pick1 = elig1 & (~elig0 | ~last_q);
`else
    pick1 = elig1 & ~elig0;
`endif
  end

  // Owner request mux and command decode; memory controls are live only in BUSY.
  always_comb begin
    own_cmd   = owner_q ? m1_cmd   : m0_cmd;
    own_addr  = owner_q ? m1_addr  : m0_addr;
    own_wdata = owner_q ? m1_wdata : m0_wdata;
    busy      = (state_q == ST_BUSY);
    own_store = (own_cmd == CMD_SW) | (own_cmd == CMD_SB);
    own_load  = ~own_store;
    // Reset gates the write strobe in the same cycle so an interrupted
    // store never reaches the memory.
    dm_we     = busy & own_store & ~rst;
    dm_sb     = busy & (own_cmd == CMD_SB);
    dm_lb     = busy & (own_cmd == CMD_LB);
    dm_lbu    = busy & (own_cmd == CMD_LBU);
    dm_addr   = busy ? own_addr  : '0;
    dm_din    = busy ? own_wdata : '0;
  end

  // Next-state logic: grant in IDLE, complete the owner's access in BUSY.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (elig0 | elig1) begin
          state_d = ST_BUSY;
          owner_d = pick1;
          last_d  = pick1;
        end
      end
      ST_BUSY: begin
        state_d = ST_IDLE;
        if (owner_q) begin
          m1_ack_d = 1'b1;
          if (own_load) m1_rdata_d = dm_dout;
        end else begin
          m0_ack_d = 1'b1;
          if (own_load) m0_rdata_d = dm_dout;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; last grant resets to m1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 32'h0;
      m1_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule
